// File: rtl/button_debounce.sv
// rtl/button_debounce.sv - push-button synchroniser, debouncer and press/release/hold strobe generator
//
// Purpose:
//   Conditions raw board push-buttons for the button/LED logic. Each channel
//   is synchronised into the clk domain, normalised to active-high and
//   debounced by its own state machine. A channel reports a clean level plus
//   single-cycle press, release and long-hold strobes.
//
// Ports:
//   clk          system clock, all state on the rising edge
//   rst          asynchronous active-low reset (0 = reset)
//   btn_raw      raw asynchronous button pins, one bit per channel
//   btn_level    debounced level, 1 = pressed
//   btn_press    one-cycle strobe on an accepted press
//   btn_release  one-cycle strobe on an accepted release
//   btn_hold     one-cycle strobe once a press has lasted HOLD_CYCLES

module button_debounce #(
  parameter int N_BUTTONS       = 2,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int HOLD_CYCLES     = 100000000,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_BUTTONS-1:0] btn_raw,
  output logic [N_BUTTONS-1:0] btn_level,
  output logic [N_BUTTONS-1:0] btn_press,
  output logic [N_BUTTONS-1:0] btn_release,
  output logic [N_BUTTONS-1:0] btn_hold
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int HW = $clog2(HOLD_CYCLES + 1);

  localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES);
  localparam logic [HW-1:0] HOLD_PRE = HW'(HOLD_CYCLES - 1);

  // Raw pin level when the button is not pressed.
  localparam logic IDLE_RAW = (ACTIVE_LOW != 0);

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_e;

  for (genvar g = 0; g < N_BUTTONS; g++) begin : g_ch
    logic          sync1_q;
    logic          sync2_q;
    state_e        state_q;
    logic [DW-1:0] deb_cnt_q;
    logic [HW-1:0] hold_cnt_q;
    logic          level_q;
    logic          press_q;
    logic          release_q;
    logic          hold_q;
    logic          pressed_in;

    // Normalised input: 1 means the button is pressed regardless of pin polarity.
    assign pressed_in = sync2_q ^ IDLE_RAW;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        // Synchroniser starts at the idle pin level so reset exit cannot look like a press.
        sync1_q    <= IDLE_RAW;
        sync2_q    <= IDLE_RAW;
        state_q    <= RELEASED;
        deb_cnt_q  <= '0;
        hold_cnt_q <= '0;
        level_q    <= 1'b0;
        press_q    <= 1'b0;
        release_q  <= 1'b0;
        hold_q     <= 1'b0;
      end else begin
        sync1_q   <= btn_raw[g];
        sync2_q   <= sync1_q;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        hold_q    <= 1'b0;

        // Hold time keeps running through release bounces and saturates, so the
        // strobe can fire only once per accepted press.
        if ((state_q == PRESSED || state_q == RELEASE_WAIT) && hold_cnt_q != HOLD_MAX) begin
          hold_cnt_q <= hold_cnt_q + 1'b1;
          if (hold_cnt_q == HOLD_PRE) begin
            hold_q <= 1'b1;
          end
        end

        case (state_q)
          RELEASED: begin
            if (pressed_in) begin
              state_q   <= PRESS_WAIT;
              deb_cnt_q <= '0;
            end
          end
          PRESS_WAIT: begin
            if (!pressed_in) begin
              state_q <= RELEASED;
            end else if (deb_cnt_q == DEB_LAST) begin
              state_q    <= PRESSED;
              press_q    <= 1'b1;
              level_q    <= 1'b1;
              hold_cnt_q <= '0;
            end else begin
              deb_cnt_q <= deb_cnt_q + 1'b1;
            end
          end
          PRESSED: begin
            if (!pressed_in) begin
              state_q   <= RELEASE_WAIT;
              deb_cnt_q <= '0;
            end
          end
          RELEASE_WAIT: begin
            if (pressed_in) begin
              state_q <= PRESSED;
            end else if (deb_cnt_q == DEB_LAST) begin
              state_q   <= RELEASED;
              release_q <= 1'b1;
              level_q   <= 1'b0;
            end else begin
              deb_cnt_q <= deb_cnt_q + 1'b1;
            end
          end
          default: begin
            state_q <= RELEASED;
          end
        endcase
      end
    end

    assign btn_level[g]   = level_q;
    assign btn_press[g]   = press_q;
    assign btn_release[g] = release_q;
    assign btn_hold[g]    = hold_q;
  end

endmodule

// File: tb/tb_button_debounce.sv
// tb/tb_button_debounce.sv - testbench for button_debounce

module tb_button_debounce;

  localparam int MAXC = 128;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] btn_raw = 2'b11;
  logic [1:0] btn_level;
  logic [1:0] btn_press;
  logic [1:0] btn_release;
  logic [1:0] btn_hold;

  always #5 clk = ~clk;

  button_debounce #(
    .N_BUTTONS      (2),
    .DEBOUNCE_CYCLES(4),
    .HOLD_CYCLES    (20),
    .ACTIVE_LOW     (1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_raw    (btn_raw),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .btn_hold   (btn_hold)
  );

  typedef struct {
    string      name;
    int         cyc;
    logic [7:0] exp;
  } sb_t;

  sb_t sb_q[$];
  int  n_vec = 0;
  int  n_bad = 0;

  // Per-scenario stimulus and expected outputs; index k = k-th rising edge of the scenario.
  logic [1:0] raw_w [MAXC];
  logic       rst_w [MAXC];
  logic [1:0] e_lvl [MAXC];
  logic [1:0] e_prs [MAXC];
  logic [1:0] e_rel [MAXC];
  logic [1:0] e_hld [MAXC];

  typedef struct {
    string      name;
    logic [1:0] mask;
    int         start;
    int         len;
    int         span;
    int         p;
    int         r;
    int         h;
  } tvec_t;

  tvec_t tbl [8];

  // Scoreboard check: outputs sampled 1 ns after each rising edge.
  initial begin
    sb_t        e;
    logic [7:0] act;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e   = sb_q.pop_front();
        act = {btn_level, btn_press, btn_release, btn_hold};
        n_vec++;
        if (act !== e.exp) begin
          n_bad++;
          $display("FAIL %s edge %0d: lvl/prs/rel/hld got %b_%b_%b_%b expected %b_%b_%b_%b",
                   e.name, e.cyc, act[7:6], act[5:4], act[3:2], act[1:0],
                   e.exp[7:6], e.exp[5:4], e.exp[3:2], e.exp[1:0]);
        end
      end
    end
  end

  task automatic scn_clear();
    for (int k = 0; k < MAXC; k++) begin
      raw_w[k] = 2'b11;
      rst_w[k] = 1'b1;
      e_lvl[k] = 2'b00;
      e_prs[k] = 2'b00;
      e_rel[k] = 2'b00;
      e_hld[k] = 2'b00;
    end
  endtask

  task automatic drive_low(input int ch, input int from, input int len);
    for (int k = from; k < from + len; k++) raw_w[k][ch] = 1'b0;
  endtask

  task automatic expect_press(input int ch, input int p, input int r, input int h);
    int stop;
    if (p >= 0) begin
      e_prs[p][ch] = 1'b1;
      stop = (r >= 0) ? r : MAXC;
      for (int k = p; k < stop; k++) e_lvl[k][ch] = 1'b1;
    end
    if (r >= 0) e_rel[r][ch] = 1'b1;
    if (h >= 0) e_hld[h][ch] = 1'b1;
  endtask

  task automatic run_scn(input string name, input int len);
    sb_t e;
    int  guard;
    for (int k = 0; k < len; k++) begin
      @(negedge clk);
      btn_raw = raw_w[k];
      rst     = rst_w[k];
      e.name  = name;
      e.cyc   = k;
      e.exp   = {e_lvl[k], e_prs[k], e_rel[k], e_hld[k]};
      sb_q.push_back(e);
    end
    guard = 0;
    while (sb_q.size() > 0 && guard < 10) begin
      @(posedge clk);
      #2;
      guard++;
    end
  endtask

  initial begin
    tbl[0] = '{"press0_long",   2'b01, 2, 40, 60,  8, 48, 28};
    tbl[1] = '{"press1_long",   2'b10, 2, 40, 60,  8, 48, 28};
    tbl[2] = '{"tap0_6",        2'b01, 2,  6, 24,  8, 14, -1};
    tbl[3] = '{"tap0_min5",     2'b01, 2,  5, 24,  8, 13, -1};
    tbl[4] = '{"tap1_4_reject", 2'b10, 2,  4, 24, -1, -1, -1};
    tbl[5] = '{"both_10",       2'b11, 2, 10, 30,  8, 18, -1};
    tbl[6] = '{"hold_edge_yes", 2'b01, 2, 20, 40,  8, 28, 28};
    tbl[7] = '{"hold_edge_no",  2'b01, 2, 19, 40,  8, 27, -1};

    // Reset with pins idle, then 50 quiet cycles.
    scn_clear();
    for (int k = 0; k < 3; k++) rst_w[k] = 1'b0;
    run_scn("reset_idle", 53);

    for (int i = 0; i < 8; i++) begin
      scn_clear();
      for (int ch = 0; ch < 2; ch++) begin
        if (tbl[i].mask[ch]) begin
          drive_low(ch, tbl[i].start, tbl[i].len);
          expect_press(ch, tbl[i].p, tbl[i].r, tbl[i].h);
        end
      end
      run_scn(tbl[i].name, tbl[i].span);
    end

    // Five 3-cycle bounces, then a real 10-cycle press.
    scn_clear();
    for (int j = 0; j < 5; j++) drive_low(0, 2 + 6 * j, 3);
    drive_low(0, 32, 10);
    expect_press(0, 38, 48, -1);
    run_scn("bounce_train", 60);

    // 2-cycle release glitch while pressed must not disturb level or hold timing.
    scn_clear();
    drive_low(0, 2, 48);
    raw_w[20][0] = 1'b1;
    raw_w[21][0] = 1'b1;
    expect_press(0, 8, 56, 28);
    run_scn("glitch_pressed", 70);

    // Reset in the middle of the press debounce; a full debounce restarts afterwards.
    scn_clear();
    drive_low(0, 2, 28);
    rst_w[6] = 1'b0;
    rst_w[7] = 1'b0;
    expect_press(0, 14, 36, 34);
    run_scn("reset_mid_wait", 50);

    if (sb_q.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain: %0d expected vectors left, required 0", sb_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
